sync_fifo_lvl: RTL and testbench

Single-clock, parametrised FIFO for intra-domain buffering between SoC subsystems that share a clock, where the dual-clock FIFO's synchroniser latency and Gray-code overhead are unnecessary. It generalises the existing FIFO in three ways:

- arbitrary (non-power-of-2) depth;
- a selectable first-word-fall-through read mode;
- fill-level and threshold reporting, plus sticky overflow/underflow error flags and a synchronous flush.

---
 rtl/sync_fifo_lvl.sv | 124 ++++++++++++
 tb/tb_sync_fifo_lvl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_lvl.sv
// Single-clock FIFO with arbitrary depth, optional first-word-fall-through,
// fill-level/threshold flags, sticky error flags and synchronous flush.
module sync_fifo_lvl #(
  parameter int D_SIZE  = 16,
  parameter int F_DEPTH = 8,
  parameter int P_SIZE  = 4,
  parameter int AF_LVL  = 6,
  parameter int AE_LVL  = 2,
  parameter int FWFT    = 0
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_wr_en,
  input  logic [D_SIZE-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic              i_flush,
  input  logic              i_err_clr,
  output logic [D_SIZE-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_almost_full,
  output logic              o_almost_empty,
  output logic [P_SIZE-1:0] o_level,
  output logic              o_overflow,
  output logic              o_underflow
);

  localparam int PW = $clog2(F_DEPTH);
  localparam logic [PW-1:0] LAST = PW'(F_DEPTH - 1);
  localparam logic [P_SIZE-1:0] L_FULL = P_SIZE'(F_DEPTH);
  localparam logic [P_SIZE-1:0] L_AF = P_SIZE'(AF_LVL);
  localparam logic [P_SIZE-1:0] L_AE = P_SIZE'(AE_LVL);

  logic [D_SIZE-1:0] mem [F_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [P_SIZE-1:0] level_nxt;
  logic              wr_ok;
  logic              rd_ok;
  logic              ov_set;
  logic              un_set;

  // Explicit wrap keeps non-power-of-2 depths correct.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign wr_ok  = i_wr_en & ~o_full & ~i_flush;
  assign rd_ok  = i_rd_en & ~o_empty & ~i_flush;
  assign ov_set = i_wr_en & o_full & ~i_flush;
  assign un_set = i_rd_en & o_empty & ~i_flush;

  always_comb begin
    level_nxt = o_level;
    if (i_flush)
      level_nxt = '0;
    else if (wr_ok & ~rd_ok)
      level_nxt = o_level + P_SIZE'(1);
    else if (rd_ok & ~wr_ok)
      level_nxt = o_level - P_SIZE'(1);
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      o_level        <= '0;
      o_full         <= 1'b0;
      o_empty        <= 1'b1;
      o_almost_full  <= 1'b0;
      o_almost_empty <= 1'b1;
      o_overflow     <= 1'b0;
      o_underflow    <= 1'b0;
    end else begin
      if (i_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_ok) wr_ptr <= inc(wr_ptr);
        if (rd_ok) rd_ptr <= inc(rd_ptr);
      end
      o_level        <= level_nxt;
      o_full         <= (level_nxt == L_FULL);
      o_empty        <= (level_nxt == '0);
      o_almost_full  <= (level_nxt >= L_AF);
      o_almost_empty <= (level_nxt <= L_AE);
      if (ov_set)
        o_overflow <= 1'b1;
      else if (i_err_clr)
        o_overflow <= 1'b0;
      if (un_set)
        o_underflow <= 1'b1;
      else if (i_err_clr)
        o_underflow <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (wr_ok) mem[wr_ptr] <= i_wr_data;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign o_rd_data  = mem[rd_ptr];
      assign o_rd_valid = ~o_empty;
    end else begin : g_reg
      logic [D_SIZE-1:0] rdata;
      logic              rvalid;
      always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
          rdata  <= '0;
          rvalid <= 1'b0;
        end else begin
          rvalid <= rd_ok;
          if (rd_ok) rdata <= mem[rd_ptr];
        end
      end
      assign o_rd_data  = rdata;
      assign o_rd_valid = rvalid;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_lvl.sv
// Bench for sync_fifo_lvl: three instances (default, depth 6, FWFT)
// checked against a queue model and a read-data scoreboard.
module tb_sync_fifo_lvl;

  logic clk = 1'b0;
  logic rstn;

  logic        we [3];
  logic        re [3];
  logic        fl [3];
  logic        ec [3];
  logic [15:0] wd [3];

  logic [15:0] rdat [3];
  logic        rvld [3];
  logic        full [3];
  logic        empty [3];
  logic        af [3];
  logic        ae [3];
  logic        ov [3];
  logic        un [3];
  logic [3:0]  lv0;
  logic [2:0]  lv1;
  logic [3:0]  lv2;

  int errs = 0;
  int checks = 0;

  int          cur;
  int          mdep;
  int          maf;
  int          mae;
  bit          mfwft;
  logic [15:0] mq [$];
  logic [15:0] xq [$];
  logic        mov;
  logic        mun;

  always #5 clk = ~clk;

  sync_fifo_lvl u_def (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_en(we[0]), .i_wr_data(wd[0]), .i_rd_en(re[0]),
    .i_flush(fl[0]), .i_err_clr(ec[0]),
    .o_rd_data(rdat[0]), .o_rd_valid(rvld[0]),
    .o_full(full[0]), .o_empty(empty[0]),
    .o_almost_full(af[0]), .o_almost_empty(ae[0]),
    .o_level(lv0), .o_overflow(ov[0]), .o_underflow(un[0])
  );

  sync_fifo_lvl #(.F_DEPTH(6), .P_SIZE(3)) u_d6 (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_en(we[1]), .i_wr_data(wd[1]), .i_rd_en(re[1]),
    .i_flush(fl[1]), .i_err_clr(ec[1]),
    .o_rd_data(rdat[1]), .o_rd_valid(rvld[1]),
    .o_full(full[1]), .o_empty(empty[1]),
    .o_almost_full(af[1]), .o_almost_empty(ae[1]),
    .o_level(lv1), .o_overflow(ov[1]), .o_underflow(un[1])
  );

  sync_fifo_lvl #(.FWFT(1)) u_fw (
    .i_clk(clk), .i_rstn(rstn),
    .i_wr_en(we[2]), .i_wr_data(wd[2]), .i_rd_en(re[2]),
    .i_flush(fl[2]), .i_err_clr(ec[2]),
    .o_rd_data(rdat[2]), .o_rd_valid(rvld[2]),
    .o_full(full[2]), .o_empty(empty[2]),
    .o_almost_full(af[2]), .o_almost_empty(ae[2]),
    .o_level(lv2), .o_overflow(ov[2]), .o_underflow(un[2])
  );

  function automatic logic [3:0] lvl_of(input int k);
    case (k)
      0:       return lv0;
      1:       return {1'b0, lv1};
      default: return lv2;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s inst=%0d got=%0h exp=%0h", tag, cur, got, exp);
    end
  endtask

  task automatic sel(input int k, input int dep, input bit fw);
    cur   = k;
    mdep  = dep;
    maf   = 6;
    mae   = 2;
    mfwft = fw;
    mq.delete();
    xq.delete();
    mov = 1'b0;
    mun = 1'b0;
  endtask

  task automatic chk_rst(input int k);
    cur = k;
    check("rst_level", 32'(lvl_of(k)), 32'd0);
    check("rst_empty", 32'(empty[k]), 32'd1);
    check("rst_full", 32'(full[k]), 32'd0);
    check("rst_ae", 32'(ae[k]), 32'd1);
    check("rst_af", 32'(af[k]), 32'd0);
    check("rst_valid", 32'(rvld[k]), 32'd0);
    check("rst_ov", 32'(ov[k]), 32'd0);
    check("rst_un", 32'(un[k]), 32'd0);
    if (k != 2) check("rst_data", 32'(rdat[k]), 32'd0);
  endtask

  task automatic cyc(input logic w, input logic [15:0] d, input logic r,
                     input logic f, input logic c);
    logic mf, me, wa, ra;
    logic [15:0] v;
    int sz;
    we[cur] = w;
    wd[cur] = d;
    re[cur] = r;
    fl[cur] = f;
    ec[cur] = c;
    mf = (mq.size() == mdep);
    me = (mq.size() == 0);
    wa = w & ~mf & ~f;
    ra = r & ~me & ~f;
    @(posedge clk);
    if (f) mq.delete();
    if (ra) begin
      v = mq.pop_front();
      if (!mfwft) xq.push_back(v);
    end
    if (wa) mq.push_back(d);
    mov = (w & mf & ~f) | (mov & ~c);
    mun = (r & me & ~f) | (mun & ~c);
    #1;
    we[cur] = 1'b0;
    re[cur] = 1'b0;
    fl[cur] = 1'b0;
    ec[cur] = 1'b0;
    sz = mq.size();
    check("level", 32'(lvl_of(cur)), 32'(sz));
    check("full", 32'(full[cur]), 32'(sz == mdep));
    check("empty", 32'(empty[cur]), 32'(sz == 0));
    check("almost_full", 32'(af[cur]), 32'(sz >= maf));
    check("almost_empty", 32'(ae[cur]), 32'(sz <= mae));
    check("overflow", 32'(ov[cur]), 32'(mov));
    check("underflow", 32'(un[cur]), 32'(mun));
    if (!mfwft) begin
      check("rd_valid", 32'(rvld[cur]), 32'(ra));
      if (xq.size() > 0) check("rd_data", 32'(rdat[cur]), 32'(xq.pop_front()));
    end else begin
      check("rd_valid", 32'(rvld[cur]), 32'(sz != 0));
      if (sz != 0) check("rd_data", 32'(rdat[cur]), 32'(mq[0]));
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      we[k] = 1'b0;
      re[k] = 1'b0;
      fl[k] = 1'b0;
      ec[k] = 1'b0;
      wd[k] = '0;
    end
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_rst(k);
    rstn = 1'b1;

    // depth 6: steady-state streaming across pointer wrap
    sel(1, 6, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h100 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'(16'h200 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 16'(16'h300 + i), 1'b0, 1'b0, 1'b0);
    check("d6_full", 32'(full[1]), 32'd1);
    cyc(1'b1, 16'h3FF, 1'b1, 1'b0, 1'b0);
    check("d6_wr_rd_full_level", 32'(lv1), 32'd5);
    check("d6_overflow", 32'(ov[1]), 32'd1);

    // first-word-fall-through
    sel(2, 8, 1'b1);
    cyc(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    check("fwft_valid", 32'(rvld[2]), 32'd1);
    check("fwft_data", 32'(rdat[2]), 32'hA5A5);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("fwft_pop", 32'(rvld[2]), 32'd0);
    cyc(1'b1, 16'h5A5A, 1'b1, 1'b0, 1'b0);
    check("fwft_wr_rd_empty_un", 32'(un[2]), 32'd1);
    cyc(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0);

    // default instance: fill, drain, errors, flush, async reset
    sel(0, 8, 1'b0);
    for (int i = 1; i <= 8; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
    check("fill_level", 32'(lv0), 32'd8);
    check("fill_full", 32'(full[0]), 32'd1);
    cyc(1'b1, 16'h0009, 1'b0, 1'b0, 1'b0);
    check("ninth_wr_ov", 32'(ov[0]), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("drain_empty", 32'(empty[0]), 32'd1);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("ninth_rd_un", 32'(un[0]), 32'd1);
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'(16'h40 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hDEAD, 1'b1, 1'b1, 1'b0);
    check("flush_level", 32'(lv0), 32'd0);
    check("flush_ov_kept", 32'(ov[0]), 32'd1);
    check("flush_un_kept", 32'(un[0]), 32'd1);
    for (int i = 0; i < 8; i++) cyc(1'b1, 16'(16'h50 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 16'hBAD0, 1'b0, 1'b0, 1'b1);
    check("clr_vs_set_ov", 32'(ov[0]), 32'd1);
    check("clr_un", 32'(un[0]), 32'd0);
    cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    check("clr_ov", 32'(ov[0]), 32'd0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    check("pre_rst_level", 32'(lv0), 32'd4);
    #2;
    rstn = 1'b0;
    #1;
    chk_rst(0);
    sel(0, 8, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    cyc(1'b1, 16'hBEEF, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
